// File: rtl/fcw_sweep_ctrl.sv
// Frequency sweep controller for a phase-accumulator NCO.
// Steps an 8-bit FCW from a start to a stop value with a per-step dwell.
module fcw_sweep_ctrl #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               hold,
    input  logic               continuous,
    input  logic [7:0]         fcw_start,
    input  logic [7:0]         fcw_stop,
    input  logic [7:0]         fcw_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [7:0]         fcw,
    output logic               acc_rst_n,
    output logic               busy,
    output logic               step_stb,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        HOLD
    } state_t;

    state_t             state_q;
    logic [7:0]         fcw_q;
    logic [7:0]         start_q;
    logic [7:0]         stop_q;
    logic [7:0]         step_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] reload_q;
    logic               up_q;
    logic               cont_q;
    logic               acc_rst_n_q;
    logic               busy_q;
    logic               step_stb_q;
    logic               done_q;

    logic [DWELL_W-1:0] reload_d;
    logic [7:0]         step_d;
    logic [8:0]         sum_d;
    logic [8:0]         dif_d;
    logic [7:0]         next_fcw_d;

    // Effective config at start time and the saturated next sweep value.
    always_comb begin
        reload_d   = '0;
        step_d     = fcw_step;
        next_fcw_d = stop_q;
        if (dwell != '0) begin
            reload_d = dwell - DWELL_W'(1);
        end
        if (fcw_step == 8'd0) begin
            step_d = 8'd1;
        end
        sum_d = {1'b0, fcw_q} + {1'b0, step_q};
        dif_d = {1'b0, fcw_q} - {1'b0, step_q};
        if (up_q) begin
            if (sum_d <= {1'b0, stop_q}) begin
                next_fcw_d = sum_d[7:0];
            end
        end else begin
            if (!dif_d[8] && (dif_d[7:0] >= stop_q)) begin
                next_fcw_d = dif_d[7:0];
            end
        end
    end

    // Sweep FSM; all outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fcw_q       <= 8'd0;
            start_q     <= 8'd0;
            stop_q      <= 8'd0;
            step_q      <= 8'd1;
            cnt_q       <= '0;
            reload_q    <= '0;
            up_q        <= 1'b1;
            cont_q      <= 1'b0;
            acc_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            step_stb_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            step_stb_q <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    fcw_q       <= 8'd0;
                    cnt_q       <= '0;
                    acc_rst_n_q <= 1'b0;
                    busy_q      <= 1'b0;
                    if (start && !abort) begin
                        state_q     <= SWEEP;
                        start_q     <= fcw_start;
                        stop_q      <= fcw_stop;
                        step_q      <= step_d;
                        reload_q    <= reload_d;
                        up_q        <= (fcw_stop >= fcw_start);
                        cont_q      <= continuous;
                        fcw_q       <= fcw_start;
                        cnt_q       <= reload_d;
                        acc_rst_n_q <= 1'b1;
                        busy_q      <= 1'b1;
                        step_stb_q  <= 1'b1;
                    end
                end
                SWEEP, HOLD: begin
                    if (abort) begin
                        state_q     <= IDLE;
                        fcw_q       <= 8'd0;
                        cnt_q       <= '0;
                        acc_rst_n_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (hold) begin
                        state_q <= HOLD;
                    end else begin
                        state_q <= SWEEP;
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - DWELL_W'(1);
                        end else if (fcw_q != stop_q) begin
                            fcw_q      <= next_fcw_d;
                            cnt_q      <= reload_q;
                            step_stb_q <= 1'b1;
                        end else if (cont_q) begin
                            fcw_q      <= start_q;
                            cnt_q      <= reload_q;
                            step_stb_q <= 1'b1;
                        end else begin
                            state_q     <= IDLE;
                            fcw_q       <= 8'd0;
                            cnt_q       <= '0;
                            acc_rst_n_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fcw       = fcw_q;
    assign acc_rst_n = acc_rst_n_q;
    assign busy      = busy_q;
    assign step_stb  = step_stb_q;
    assign done      = done_q;

endmodule
